// File: rtl/bcd_pkg.sv
// Shared types, segment constants and the BCD-to-seven-segment table
// used by the display scan blocks.
package bcd_pkg;

  typedef enum logic [1:0] {BLANK_T, TENS_ON, BLANK_O, ONES_ON} scan_state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } digits_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational 4-bit BCD to active-low seven-segment decoder.
module bcd_seg_decode
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = seg7_decode(digit);

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed common-anode seven-segment scanner with frame-aligned
// digit updates. Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_seg_scan
  import bcd_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOAD,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       FRAME
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LAST_ON    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);

  scan_state_e   state, next_state;
  logic [CW-1:0] count;
  digits_t       disp, disp_next, stage, stage_next, incoming;
  logic          pend, pend_next;
  logic          done, boundary;
  logic [3:0]    dec_in;
  logic [6:0]    dec_seg, seg_next;
  logic [1:0]    an_next;

  assign incoming = '{tens: TENS, ones: ONES};

  always_comb begin
    next_state = state;
    done       = (state == BLANK_T || state == BLANK_O) ? (count == LAST_BLANK)
                                                        : (count == LAST_ON);
    if (done) begin
      case (state)
        BLANK_T: next_state = TENS_ON;
        TENS_ON: next_state = BLANK_O;
        BLANK_O: next_state = ONES_ON;
        default: next_state = BLANK_T;
      endcase
    end
    boundary = (state == ONES_ON) && done;

    disp_next  = disp;
    stage_next = stage;
    pend_next  = pend;
    if (LOAD) stage_next = incoming;
    // A load landing on the boundary edge bypasses staging entirely.
    if (boundary) begin
      if (LOAD) begin
        disp_next = incoming;
        pend_next = 1'b0;
      end else if (pend) begin
        disp_next = stage;
        pend_next = 1'b0;
      end
    end else if (LOAD) begin
      pend_next = 1'b1;
    end
  end

  assign dec_in = (next_state == TENS_ON) ? disp_next.tens : disp_next.ones;

  bcd_seg_decode u_decode (
    .digit (dec_in),
    .seg   (dec_seg)
  );

  always_comb begin
    seg_next = SEG_OFF;
    an_next  = 2'b11;
    case (next_state)
      TENS_ON: begin
        an_next  = 2'b01;
        seg_next = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_next.tens == 4'd0) seg_next = SEG_OFF;
`endif
      end
      ONES_ON: begin
        an_next  = 2'b10;
        seg_next = dec_seg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= BLANK_T;
      count <= '0;
      disp  <= '0;
      stage <= '0;
      pend  <= 1'b0;
      SEG   <= SEG_OFF;
      AN    <= 2'b11;
      FRAME <= 1'b0;
    end else begin
      state <= next_state;
      count <= (next_state != state) ? '0 : count + 1'b1;
      disp  <= disp_next;
      stage <= stage_next;
      pend  <= pend_next;
      SEG   <= seg_next;
      AN    <= an_next;
      FRAME <= boundary;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomised and directed bench for bcd_seg_scan (REFRESH_DIV=4, BLANK_CYCLES=2)
// against a frame-position reference model.
module tb_bcd_seg_scan;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LOAD = 1'b0;
  logic [3:0] TENS = '0;
  logic [3:0] ONES = '0;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       FRAME;

  int total = 0;
  int bad   = 0;

  bcd_seg_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .TENS(TENS), .ONES(ONES),
    .SEG(SEG), .AN(AN), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  localparam int FRAME_LEN = 12;
  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  // Model: edges since reset, shown digits, staged digits, pending flag.
  int         m_p = 0;
  logic [3:0] m_dt = 0, m_do = 0, m_st = 0, m_so = 0;
  logic       m_pend = 0, m_frame = 0;

  task automatic step(input logic rst, input logic ld, input logic [3:0] t, input logic [3:0] o);
    RESET = rst; LOAD = ld; TENS = t; ONES = o;
    @(posedge CLK);
    if (rst) begin
      m_p = 0; m_dt = 0; m_do = 0; m_st = 0; m_so = 0; m_pend = 0; m_frame = 0;
    end else begin
      m_p++;
      m_frame = (m_p % FRAME_LEN == 0);
      if (m_frame) begin
        if (ld) begin m_dt = t; m_do = o; m_pend = 0; end
        else if (m_pend) begin m_dt = m_st; m_do = m_so; m_pend = 0; end
      end else if (ld) begin
        m_st = t; m_so = o; m_pend = 1;
      end
    end
    #1;
    LOAD = 1'b0;
  endtask

  function automatic logic [9:0] exp_vec();
    int ph = m_p % FRAME_LEN;
    logic [6:0] s = 7'h7F;
    logic [1:0] a = 2'b11;
    if (ph >= 2 && ph <= 5) begin
      a = 2'b01; s = segtab[m_dt];
`ifdef LEADING_ZERO_BLANK_EN
      if (m_dt == 4'd0) s = 7'h7F;
`endif
    end else if (ph >= 8) begin
      a = 2'b10; s = segtab[m_do];
    end
    return {s, a, m_frame};
  endfunction

  function automatic int cycles_to(input int ph);
    return ((ph - (m_p % FRAME_LEN) + FRAME_LEN - 1) % FRAME_LEN) + 1;
  endfunction

  task automatic test_reset();
    repeat (3) begin
      step(1, 0, 0, 0);
      total++;
      if ({SEG, AN, FRAME} !== {7'h7F, 2'b11, 1'b0}) begin
        bad++; $display("FAIL reset_hold got=%b want=%b", {SEG, AN, FRAME}, {7'h7F, 2'b11, 1'b0});
      end
    end
    for (int i = 1; i <= FRAME_LEN; i++) begin
      step(0, 0, 0, 0);
      total++;
      if ({SEG, AN, FRAME} !== exp_vec()) begin
        bad++; $display("FAIL first_frame c=%0d got=%b want=%b", i, {SEG, AN, FRAME}, exp_vec());
      end
      if (i == 3 || i == 12) begin
        total++;
        if ((i == 3 && {SEG, AN} !== {7'b1000000, 2'b01}) || (i == 12 && FRAME !== 1'b1)) begin
          bad++; $display("FAIL first_frame_fixed c=%0d got=%b", i, {SEG, AN, FRAME});
        end
      end
    end
  endtask

  task automatic test_load_midframe();
    repeat (cycles_to(3)) step(0, 0, 0, 0);
    step(0, 1, 4'd1, 4'd4);
    repeat (cycles_to(3)) begin
      step(0, 0, 0, 0);
      total++;
      if ({SEG, AN, FRAME} !== exp_vec()) begin
        bad++; $display("FAIL load_mid p=%0d got=%b want=%b", m_p, {SEG, AN, FRAME}, exp_vec());
      end
    end
    total++;
    if ({SEG, AN} !== {7'b1111001, 2'b01}) begin
      bad++; $display("FAIL load_mid_tens got=%b want=%b", {SEG, AN}, {7'b1111001, 2'b01});
    end
    repeat (cycles_to(9)) step(0, 0, 0, 0);
    total++;
    if ({SEG, AN} !== {7'b0011001, 2'b10}) begin
      bad++; $display("FAIL load_mid_ones got=%b want=%b", {SEG, AN}, {7'b0011001, 2'b10});
    end
  endtask

  task automatic test_two_loads();
    repeat (cycles_to(1)) step(0, 0, 0, 0);
    step(0, 1, 4'd0, 4'd3);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 4'd1, 4'd0);
    repeat (cycles_to(3)) begin
      step(0, 0, 0, 0);
      total++;
      if ({SEG, AN, FRAME} !== exp_vec()) begin
        bad++; $display("FAIL two_loads p=%0d got=%b want=%b", m_p, {SEG, AN, FRAME}, exp_vec());
      end
    end
    total++;
    if (SEG !== 7'b1111001) begin
      bad++; $display("FAIL two_loads_tens got=%b want=%b", SEG, 7'b1111001);
    end
    step(0, 1, 4'd0, 4'd3);
    repeat (cycles_to(3)) step(0, 0, 0, 0);
    total++;
`ifdef LEADING_ZERO_BLANK_EN
    if ({SEG, AN} !== {7'h7F, 2'b01}) begin
      bad++; $display("FAIL lead_zero got=%b want=%b", {SEG, AN}, {7'h7F, 2'b01});
    end
`else
    if ({SEG, AN} !== {7'b1000000, 2'b01}) begin
      bad++; $display("FAIL tens_zero got=%b want=%b", {SEG, AN}, {7'b1000000, 2'b01});
    end
`endif
  endtask

  task automatic test_invalid();
    step(0, 1, 4'hA, 4'hF);
    repeat (cycles_to(4)) step(0, 0, 0, 0);
    total++;
    if ({SEG, AN} !== {7'b0111111, 2'b01}) begin
      bad++; $display("FAIL invalid_tens got=%b want=%b", {SEG, AN}, {7'b0111111, 2'b01});
    end
    repeat (cycles_to(10)) step(0, 0, 0, 0);
    total++;
    if ({SEG, AN} !== {7'b0111111, 2'b10}) begin
      bad++; $display("FAIL invalid_ones got=%b want=%b", {SEG, AN}, {7'b0111111, 2'b10});
    end
  endtask

  task automatic test_boundary_load();
    repeat (cycles_to(11)) step(0, 0, 0, 0);
    step(0, 1, 4'd7, 4'd2);
    total++;
    if (FRAME !== 1'b1) begin
      bad++; $display("FAIL boundary_frame got=%b want=1", FRAME);
    end
    repeat (FRAME_LEN - 1) begin
      step(0, 0, 0, 0);
      total++;
      if ({SEG, AN, FRAME} !== exp_vec()) begin
        bad++; $display("FAIL boundary_load p=%0d got=%b want=%b", m_p, {SEG, AN, FRAME}, exp_vec());
      end
    end
    total++;
    if ({SEG, AN} !== {7'b0100100, 2'b10}) begin
      bad++; $display("FAIL boundary_ones got=%b want=%b", {SEG, AN}, {7'b0100100, 2'b10});
    end
  endtask

  task automatic test_reset_pending();
    repeat (cycles_to(8)) step(0, 0, 0, 0);
    step(0, 1, 4'd9, 4'd8);
    step(1, 0, 0, 0);
    total++;
    if ({SEG, AN, FRAME} !== {7'h7F, 2'b11, 1'b0}) begin
      bad++; $display("FAIL reset_mid got=%b want=%b", {SEG, AN, FRAME}, {7'h7F, 2'b11, 1'b0});
    end
    repeat (2 * FRAME_LEN) begin
      step(0, 0, 0, 0);
      total++;
      if ({SEG, AN, FRAME} !== exp_vec()) begin
        bad++; $display("FAIL reset_pend p=%0d got=%b want=%b", m_p, {SEG, AN, FRAME}, exp_vec());
      end
      if (AN == 2'b01) begin
        total++;
        if (SEG !== 7'b1000000) begin
          bad++; $display("FAIL reset_discard got=%b want=%b", SEG, 7'b1000000);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      step(($urandom % 97) == 0, ($urandom % 6) == 0, 4'($urandom % 16), 4'($urandom % 16));
      total++;
      if ({SEG, AN, FRAME} !== exp_vec()) begin
        bad++; $display("FAIL random p=%0d got=%b want=%b", m_p, {SEG, AN, FRAME}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_midframe();
    test_two_loads();
    test_invalid();
    test_boundary_load();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the binary-to-BCD stage. Takes its two BCD digits (tens, ones) and drives a two-digit, common-anode, multiplexed seven-segment display.
- A refresh timer alternates the two digit enables, with a short all-off blanking interval between digits to prevent ghosting.
- New digits are captured on a LOAD strobe but only reach the display at a frame boundary, so the display never tears mid-scan.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is lit per frame; must be >= 2.
- BLANK_CYCLES, 16: clock cycles of all-off between digits; must be >= 1.
- Counter width is $clog2 of max(REFRESH_DIV, BLANK_CYCLES).

Ports:
- CLK  input  1  system clock, all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- LOAD  input  1  one-cycle strobe; sample TENS/ONES this cycle.
- TENS  input  4  BCD tens digit from the bin2bcd stage.
- ONES  input  4  BCD ones digit from the bin2bcd stage.
- SEG  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- AN  output  2  digit enables, active-low; AN[1] = tens, AN[0] = ones.
- FRAME  output  1  one-cycle pulse marking the frame boundary / display update.

Behaviour:
- Interface: one clock CLK; reset RESET is synchronous and active-high.
- States: BLANK_T, TENS_ON, BLANK_O, ONES_ON.
  - BLANK_T lasts BLANK_CYCLES, then goes to TENS_ON.
  - TENS_ON lasts REFRESH_DIV, then goes to BLANK_O.
  - BLANK_O lasts BLANK_CYCLES, then goes to ONES_ON.
  - ONES_ON lasts REFRESH_DIV, then goes to BLANK_T.
  - Frame length is 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Dwell counter: clears on every state change and counts up otherwise. A state exits when count == its dwell-1.
- SEG/AN are registers loaded from the next-state/next-data values. They therefore change on the same edge as the state register, with no additional latency.
  - TENS_ON: AN = 2'b01, SEG = decode(disp_tens).
  - ONES_ON: AN = 2'b10, SEG = decode(disp_ones).
  - BLANK_*: AN = 2'b11, SEG = 7'h7F.
- Decode values (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Codes 10–15 are invalid BCD and display a dash, 0111111.
- Staging:
  - LOAD=1 at an edge writes TENS/ONES into staging and sets PEND.
  - LOAD while PEND is already set overwrites staging; the latest value wins.
- Frame boundary: the edge on which ONES_ON transitions to BLANK_T.
  - FRAME=1 for the cycle following that edge.
  - If PEND is set, display regs take staging and PEND clears on the boundary edge.
- LOAD on the boundary edge itself: display regs take the incoming TENS/ONES directly; PEND stays 0.
- Reset values:
  - state = BLANK_T, count = 0.
  - display regs = 0, staging = 0, PEND = 0.
  - SEG = 7'h7F, AN = 2'b11, FRAME = 0.
- Reset mid-frame aborts the scan. The frame restarts from BLANK_T and any pending load is discarded.
- RESET has priority over LOAD.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during TENS_ON with disp_tens == 0, SEG = 7'h7F while AN still = 2'b01. Scan timing is unchanged.
- Undefined: a tens value of 0 displays "0".

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum: BLANK_T, TENS_ON, BLANK_O, ONES_ON;
  - the segment constants SEG_OFF = 7'h7F and SEG_DASH = 7'b0111111;
  - a seg7_decode function for the 4-bit to 7-bit table.
- One natural sub-module: bcd_seg_decode, a combinational 4-to-7 decoder. Reusable by later display blocks.
- The FSM, counter and staging logic stay in bcd_seg_scan.

Test Plan:
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=2, giving a 12-cycle frame.
- Reset held 3 cycles, then released:
  - SEG = 7F and AN = 11 for 2 cycles.
  - Then AN = 01, SEG = 1000000 for 4 cycles; AN = 11 for 2 cycles; AN = 10, SEG = 1000000 for 4 cycles.
  - FRAME pulses at cycle 12.
- LOAD with TENS=1, ONES=4 mid-frame:
  - The current frame still shows "00".
  - The next frame shows tens 1111001 and ones 0011001; PEND clears at FRAME.
- Two LOADs in one frame, 0/3 then 1/0:
  - The next frame shows 1/0 only.
  - With LEADING_ZERO_BLANK_EN, a load of 0/3 shows tens SEG = 7F with AN = 01.
- LOAD with TENS=4'hA, ONES=4'hF: both digits show 0111111.
- LOAD coinciding with the boundary edge: the new digits appear in the frame that starts on that edge.
- RESET asserted during ONES_ON with PEND set:
  - Next cycle: SEG = 7F, AN = 11, display returns to 0.
  - The pending value never appears.
